// File: rtl/serial_subtractor_nb_if.sv
// Handshake/operand bundle for serial_subtractor_nb.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_nb_if #(
   parameter int unsigned N = 4
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [N-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;

   // Requester side: issues operands, observes result
   modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
   // Subtractor side
   modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
`else
   // Requester side: issues operands, observes result
   modport master (output start, a, b, bin, input busy, done, d, bout);
   // Subtractor side
   modport slave  (input start, a, b, bin, output busy, done, d, bout);
`endif
endinterface

// File: rtl/serial_subtractor_nb.sv
// Bit-serial N-bit subtractor d = a - b - bin, one bit per clock, LSB first.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag, sign bits captured at accept).
module serial_subtractor_nb #(
   parameter int unsigned N = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_subtractor_nb_if.slave bus
);
   localparam int unsigned CW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic [N-1:0]  r_res;
   logic [N-1:0]  r_d;
   logic [CW-1:0] r_cnt;
   logic          r_br;
   logic          r_busy;
   logic          r_done;
   logic          r_bout;
   logic          w_accept;
   logic          w_last;
   logic          w_diff;
   logic          w_br_nxt;
`ifdef SERIAL_SUB_OVF_EN
   logic          r_sa;
   logic          r_sb;
   logic          r_ovf;
`endif

   // Accept window, final bit-cycle and one-bit full-subtractor cell
   always_comb begin
      w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
      w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(N - 1));
      w_diff   = r_a[0] ^ r_b[0] ^ r_br;
      w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = bus.start ? S_SHIFT : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath: load on accept, shift one bit per SHIFT cycle, publish result on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_d    <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_ovf  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a    <= bus.a;
         r_b    <= bus.b;
         r_br   <= bus.bin;
         r_cnt  <= '0;
         r_busy <= 1'b1;
         r_done <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_sa   <= bus.a[N-1];
         r_sb   <= bus.b[N-1];
`endif
      end else if (r_state == S_SHIFT) begin
         r_a   <= {1'b0, r_a[N-1:1]};
         r_b   <= {1'b0, r_b[N-1:1]};
         r_br  <= w_br_nxt;
         r_res <= {w_diff, r_res[N-1:1]};
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_d    <= {w_diff, r_res[N-1:1]};
            r_bout <= w_br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // w_diff is the result sign bit on the final step
            r_ovf  <= (r_sa != r_sb) && (w_diff != r_sa);
`endif
         end
      end else begin
         r_done <= 1'b0;
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.d    = r_d;
   assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Scoreboard bench for serial_subtractor_nb (N=4); ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor_nb;
   localparam int unsigned N   = 4;
   localparam int unsigned PER = 10;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   time  mon_t;

   typedef struct {
      logic [N-1:0] d;
      logic         bout;
      logic         ovf;
      time          t_done;
   } exp_t;

   exp_t sb[$];

   serial_subtractor_nb_if #(.N(N)) bus ();

   serial_subtractor_nb #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #(PER / 2) clk = ~clk;

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned and signed views
   function automatic exp_t model(input int a, input int b, input int bi);
      exp_t e;
      int   diff;
      int   sa;
      int   sbv;
      int   sdiff;
      diff   = a - b - bi;
      e.d    = N'(diff);
      e.bout = (diff < 0);
      sa     = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
      sbv    = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
      sdiff  = sa - sbv - bi;
      e.ovf  = (sdiff > (1 << (N - 1)) - 1) || (sdiff < -(1 << (N - 1)));
      e.t_done = 0;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge with operands scrambled
   task automatic issue(input int a, input int b, input int bi);
      exp_t e;
      bus.a     = N'(a);
      bus.b     = N'(b);
      bus.bin   = bi[0];
      bus.start = 1'b1;
      @(posedge clk);
      e = model(a, b, bi);
      e.t_done = $time + N * PER;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = N'($urandom);
      bus.b     = N'($urandom);
      bus.bin   = 1'($urandom);
   endtask

   // Waits (bounded) for done at a negedge, checking busy along the way
   task automatic wait_done();
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < int'(N) + 4) begin
         check("busy_during_op", 32'(bus.busy), 32'd1);
         @(negedge clk);
         k++;
      end
      if (bus.done !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", bus.done, k);
      end else begin
         check("busy_at_done", 32'(bus.busy), 32'd0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every done pulse
   always @(posedge clk) begin
      mon_t = $time;
      #1;
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: done=1 with 0 pending ops, expected none (t=%0t)", mon_t);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_d", 32'(bus.d), 32'(e.d));
            check("result_bout", 32'(bus.bout), 32'(e.bout));
            check("done_latency", 32'(mon_t), 32'(e.t_done));
`ifdef SERIAL_SUB_OVF_EN
            check("result_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
         end
      end
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      idle(3);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_d", 32'(bus.d), 32'd0);
      check("reset_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
      rst_n = 1'b1;
      idle(2);

      // Basic and borrow cases, then hold after done
      issue(9, 3, 0);
      wait_done();
      idle(2);
      issue(3, 9, 0);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_d", 32'(bus.d), 32'd10);
         check("hold_bout", 32'(bus.bout), 32'd1);
      end

      // Full wrap cases, back-to-back
      issue(0, 0, 1);
      wait_done();
      issue(15, 15, 1);
      wait_done();
      idle(1);

      // Start during busy must be ignored
      issue(12, 5, 0);
      bus.a = 4'd1;
      bus.b = 4'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      idle(N + 2);

      // Signed overflow corners
      issue(8, 1, 0);
      wait_done();
      issue(7, 15, 0);
      wait_done();
      issue(5, 3, 0);
      wait_done();
      idle(1);

      // Reset in the middle of an operation
      issue(6, 2, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_d", 32'(bus.d), 32'd0);
      check("midrst_bout", 32'(bus.bout), 32'd0);
      sb.delete();
      idle(2);
      rst_n = 1'b1;
      idle(N + 3);
      issue(11, 4, 1);
      wait_done();
      idle(1);

      // Exhaustive sweep, back-to-back
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int bi = 0; bi < 2; bi++) begin
               issue(a, b, bi);
               wait_done();
            end
      idle(2);

      // Random operands with random gaps
      for (int i = 0; i < 200; i++) begin
         issue(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(1, 0)));
         wait_done();
         idle(int'($urandom_range(2, 0)));
      end

      idle(N + 2);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
